// File: rtl/div_seq.sv
// Sequential restoring divider: NW-bit dividend by DW-bit divisor, one quotient bit per clock.
// Same start/fin handshake as the shift-add multiplier; dz flags a zero divisor.
module div_seq #(
    parameter int NW = 16,
    parameter int DW = 8
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [NW-1:0] N,
    input  logic [DW-1:0] D,
    input  logic          start,
    output logic [NW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          fin,
    output logic          dz
);

    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_reg;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so one register carries both.
    logic [NW-1:0] work_reg;
    logic [DW-1:0] dvs_reg;
    logic [DW-1:0] part_reg;
    logic [CW-1:0] count_reg;

    logic [DW:0]   trial;
    logic          take;
    logic [DW-1:0] diff;
    logic [DW-1:0] part_next;
    logic [NW-1:0] work_next;

    // The partial is always below the divisor, so the shifted trial needs only
    // one extra bit for the compare; the subtraction result fits back in DW bits.
    always_comb begin
        trial     = {part_reg, work_reg[NW-1]};
        take      = (trial >= {1'b0, dvs_reg});
        diff      = trial[DW-1:0] - dvs_reg;
        part_next = take ? diff : trial[DW-1:0];
        work_next = {work_reg[NW-2:0], take};
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            dvs_reg   <= '0;
            part_reg  <= '0;
            count_reg <= '0;
            Q         <= '0;
            R         <= '0;
            fin       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (D != '0) begin
                            work_reg  <= N;
                            dvs_reg   <= D;
                            part_reg  <= '0;
                            count_reg <= '0;
                            state_reg <= CALC;
                        end else begin
                            Q         <= '1;
                            R         <= '1;
                            dz        <= 1'b1;
                            fin       <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                CALC: begin
                    work_reg  <= work_next;
                    part_reg  <= part_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        Q         <= work_next;
                        R         <= part_next;
                        dz        <= 1'b0;
                        fin       <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    fin       <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: cycle-level reference model built from plain / and %,
// checked every cycle, plus literal expectations for a few known divisions.
module tb_div_seq;

    localparam int NW = 16;
    localparam int DW = 8;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NW-1:0] N = '0;
    logic [DW-1:0] D = '0;
    logic [NW-1:0] Q;
    logic [DW-1:0] R;
    logic          fin;
    logic          dz;

    int tests = 0;
    int fails = 0;

    div_seq #(.NW(NW), .DW(DW)) dut (
        .ck(ck), .rst(rst), .N(N), .D(D), .start(start),
        .Q(Q), .R(R), .fin(fin), .dz(dz)
    );

    always #5 ck = ~ck;

    // Reference model: remaining cycles until a result appears, and the result itself.
    int            m_rem = 0;
    logic          m_fin = 1'b0;
    logic [NW-1:0] m_q = '0;
    logic [DW-1:0] m_r = '0;
    logic          m_dz = 1'b0;
    logic [NW-1:0] p_q = '0;
    logic [DW-1:0] p_r = '0;
    bit            chk_en = 1'b0;

    always @(posedge ck) begin
        if (rst) begin
            m_rem = 0; m_fin = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0;
            chk_en = 1'b1;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_fin = 1'b1; m_q = p_q; m_r = p_r; m_dz = 1'b0;
            end
        end else if (start) begin
            if (D == '0) begin
                m_fin = 1'b1; m_q = '1; m_r = '1; m_dz = 1'b1;
            end else begin
                p_q   = NW'(int'(N) / int'(D));
                p_r   = DW'(int'(N) % int'(D));
                m_rem = NW;
            end
        end
    end

    always @(negedge ck) begin
        if (chk_en) begin
            tests++;
            if (fin !== m_fin || Q !== m_q || R !== m_r || dz !== m_dz) begin
                fails++;
                $display("FAIL model t=%0t: got fin=%b Q=%h R=%h dz=%b, want fin=%b Q=%h R=%h dz=%b",
                         $time, fin, Q, R, dz, m_fin, m_q, m_r, m_dz);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic do_op(input logic [NW-1:0] n, input logic [DW-1:0] d,
                         output int lat, output logic [NW-1:0] q,
                         output logic [DW-1:0] r, output logic z);
        @(posedge ck); #1;
        N = n; D = d; start = 1'b1;
        @(posedge ck); #1;
        start = 1'b0;
        lat = 0;
        while (fin !== 1'b1 && lat < 100) begin
            @(posedge ck); #1;
            lat++;
        end
        if (fin !== 1'b1) begin
            tests++; fails++;
            $display("FAIL timeout: no fin within 100 cycles for N=%h D=%h", n, d);
        end
        q = Q; r = R; z = dz;
        tests++;
        if (d != '0) begin
            if (int'(q) * int'(d) + int'(r) != int'(n) || r >= d || z !== 1'b0) begin
                fails++;
                $display("FAIL invariant N=%h D=%h: got Q=%h R=%h dz=%b", n, d, q, r, z);
            end
        end else if (z !== 1'b1 || q !== '1 || r !== '1) begin
            fails++;
            $display("FAIL divzero N=%h: got Q=%h R=%h dz=%b, want Q=ffff R=ff dz=1", n, q, r, z);
        end
        @(posedge ck); #1;
        chk("fin_one_cycle", int'(fin), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          z;
        int            last;
        int            nf;
        int            seen;
        int unsigned   sel;

        repeat (3) @(posedge ck);
        #1 rst = 1'b0;
        chk("reset_q", int'(Q), 0);
        chk("reset_r", int'(R), 0);
        chk("reset_fin", int'(fin), 0);
        chk("reset_dz", int'(dz), 0);

        do_op(16'd1000, 8'd7, lat, q, r, z);
        chk("lat_1000_7", lat, 16);
        chk("q_1000_7", int'(q), 'h8E);
        chk("r_1000_7", int'(r), 6);
        chk("dz_1000_7", int'(z), 0);

        do_op(16'hFFFF, 8'hFF, lat, q, r, z);
        chk("q_ffff_ff", int'(q), 'h101);
        chk("r_ffff_ff", int'(r), 0);

        do_op(16'd5, 8'd9, lat, q, r, z);
        chk("q_5_9", int'(q), 0);
        chk("r_5_9", int'(r), 5);

        do_op(16'hFFFF, 8'd1, lat, q, r, z);
        chk("q_ffff_1", int'(q), 'hFFFF);
        chk("r_ffff_1", int'(r), 0);

        do_op(16'h1234, 8'd0, lat, q, r, z);
        chk("lat_dz", lat, 0);
        chk("q_dz", int'(q), 'hFFFF);
        chk("r_dz", int'(r), 'hFF);
        chk("dz_dz", int'(z), 1);

        do_op(16'd10, 8'd3, lat, q, r, z);
        chk("q_10_3", int'(q), 3);
        chk("r_10_3", int'(r), 1);
        chk("dz_10_3", int'(z), 0);

        // start held high with operands changing every cycle
        @(posedge ck); #1;
        N = 16'($urandom); D = 8'($urandom_range(1, 255)); start = 1'b1;
        last = -1; nf = 0;
        for (int cyc = 0; cyc < 92; cyc++) begin
            @(posedge ck); #1;
            if (fin === 1'b1) begin
                if (last >= 0) chk("b2b_gap", cyc - last, NW + 2);
                last = cyc;
                nf++;
            end
            N = 16'($urandom); D = 8'($urandom_range(1, 255));
        end
        start = 1'b0;
        chk("b2b_fins", nf, 5);
        repeat (20) @(posedge ck);

        // reset during iteration 8
        @(posedge ck); #1;
        N = 16'd1000; D = 8'd7; start = 1'b1;
        @(posedge ck); #1;
        start = 1'b0;
        repeat (7) @(posedge ck);
        #1 rst = 1'b1;
        @(posedge ck); #1;
        rst = 1'b0;
        chk("rst_q", int'(Q), 0);
        chk("rst_r", int'(R), 0);
        chk("rst_fin", int'(fin), 0);
        chk("rst_dz", int'(dz), 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge ck); #1;
            if (fin === 1'b1) seen++;
        end
        chk("rst_no_fin", seen, 0);
        do_op(16'd1000, 8'd7, lat, q, r, z);
        chk("q_after_rst", int'(q), 'h8E);
        chk("r_after_rst", int'(r), 6);

        // incrementing sweep over small operands
        for (int d = 0; d < 4; d++) begin
            for (int n = 0; n < 16; n++) begin
                do_op(NW'(n), DW'(d), lat, q, r, z);
            end
        end

        // random operands, biased towards zero and all-ones divisors
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0)      do_op(16'($urandom), 8'd0, lat, q, r, z);
            else if (sel == 1) do_op(16'($urandom), 8'hFF, lat, q, r, z);
            else               do_op(16'($urandom), 8'($urandom), lat, q, r, z);
        end

        repeat (2) @(posedge ck);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
